// File: rtl/im_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings and
// frame/word byte-order constants.
package im_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = BYTES_PER_WORD * 8;

  // Length field is big-endian: first byte lands at this bit offset
  localparam int LEN_HI_LSB     = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and IM write port of the loader. The slave side is the
// loader itself; the master side is the host link plus the IM it writes.
interface im_loader_if #(
  parameter int AW = 8,
  parameter int BW = 32
);
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [BW-1:0] im_wdata;

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, im_we, im_addr, im_wdata
  );

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/im_loader_word_assembler.sv
// Big-endian word assembler: shifts bytes in MSB first, counts bytes within
// the word and keeps a running XOR of every byte shifted in.
module im_word_assembler
  import im_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_nxt,
  output logic [7:0]        acc,
  output logic              last
);
  logic [WORD_W-1:0]     word;
  logic [BYTE_CNT_W-1:0] cnt;

  // Next word is exposed so the caller can latch it on the 4th-byte edge
  assign word_nxt = {word[WORD_W-9:0], byte_in};
  assign last     = shift_en && (cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (clear) begin
      word <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      word <= word_nxt;
      acc  <= acc ^ byte_in;
      cnt  <= cnt + BYTE_CNT_W'(1);
    end
  end
endmodule

// File: rtl/im_loader.sv
// Framed program-image loader: LEN_HI, LEN_LO, 4*N data bytes, XOR checksum.
// Writes big-endian words into IM and holds the CPU while loading.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int bit_width  = 32,
  parameter int addr_width = 8
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  im_loader_if.slave          bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err,
  output logic [addr_width:0] words_loaded
);
  localparam int          WL_W  = addr_width + 1;
  localparam logic [16:0] MAX_N = 17'd1 << addr_width;

  logic [2:0]        state;
  logic [15:0]       n;
  logic [15:0]       n_full;
  logic [16:0]       wl_next;
  logic              xfer;
  logic              can_start;
  logic              shift_en;
  logic              asm_last;
  logic [WORD_W-1:0] asm_word;
  logic [7:0]        asm_acc;

  assign bus.byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                          (state == S_DATA)   || (state == S_CSUM);
  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign can_start = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign shift_en  = xfer && (state == S_DATA);
  assign n_full    = {n[LEN_HI_LSB +: 8], bus.byte_in};
  assign wl_next   = 17'(words_loaded) + 17'd1;

  im_word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (can_start),
    .shift_en (shift_en),
    .byte_in  (bus.byte_in),
    .word_nxt (asm_word),
    .acc      (asm_acc),
    .last     (asm_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      n            <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
    end else begin
      bus.im_we <= 1'b0;
      if (can_start) begin
        state        <= S_LEN_HI;
        n            <= '0;
        cpu_hold     <= 1'b1;
        done         <= 1'b0;
        err          <= 1'b0;
        words_loaded <= '0;
      end else begin
        case (state)
          S_LEN_HI: if (xfer) begin
            n[LEN_HI_LSB +: 8] <= bus.byte_in;
            state              <= S_LEN_LO;
          end
          S_LEN_LO: if (xfer) begin
            n <= n_full;
            // Oversized images abort before any IM write
            if ({1'b0, n_full} > MAX_N) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else if (n_full == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: if (asm_last) begin
            state        <= S_WRITE;
            bus.im_we    <= 1'b1;
            bus.im_addr  <= words_loaded[addr_width-1:0];
            bus.im_wdata <= bit_width'(asm_word);
          end
          S_WRITE: begin
            words_loaded <= words_loaded + WL_W'(1);
            state        <= (wl_next < {1'b0, n}) ? S_DATA : S_CSUM;
          end
          S_CSUM: if (xfer) begin
            if (bus.byte_in == asm_acc) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
